or_reduce_pipe: RTL and testbench
=================================

// Module: or_reduce_pipe
// PURPOSE
//  Parametrised, pipelined successor to the fixed 4-input OR. Reduces N_IN masked inputs to one bit,
//  selectable per sample as OR or AND, through a registered radix-4 tree.
//  Tracks result edges, a sticky flag and a saturating rise counter for status/interrupt logic.
// PARAMETERS
//  N_IN   16  number of input lanes (>=1)
//  CNT_W  8   width of saturating rise-event counter (>=1)
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  in_vld       in   1      sample valid
//  in_data      in   N_IN   lane values
//  in_mask      in   N_IN   1 = lane participates
//  in_mode_and  in   1      0 = OR reduce, 1 = AND reduce (sampled with in_data)
//  sticky_clr   in   1      clears out_sticky and out_rise_cnt
//  out_vld      out  1      result valid, in_vld delayed L cycles
//  out_res      out  1      reduction result; holds last valid value when out_vld=0
//  out_rise     out  1      1-cycle pulse: valid result 0->1
//  out_fall     out  1      1-cycle pulse: valid result 1->0
//  out_sticky   out  1      set by any valid result of 1
//  out_rise_cnt out  CNT_W  saturating count of out_rise pulses
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all pipeline data/valid regs, out_* and prev-result reg <= 0. In-flight samples discarded.
//  - Lane pre-mask: OR: d&m; AND: d|~m. Mask all-zero: OR gives 0, AND gives 1.
//  - Tree: each level ORs/ANDs groups of 4 and registers. Partial groups are padded with identity (0 for OR, 1 for AND).
//  - Levels L = max(1, ceil(log4(N_IN))). N_IN=1 uses one pass-through register.
//  - Latency: sample at edge t -> out_vld/out_res at edge t+L. Full throughput, no backpressure.
//  - in_vld=0 creates a bubble; valid and mode travel with the data.
//  - out_res updates only when the final-stage valid=1; otherwise it holds.
//  - Edge detect compares against prev valid result (0 after reset), so a first valid 1 pulses out_rise.
//    out_rise/out_fall are 0 in cycles with out_vld=0.
//  - out_sticky next = (out_sticky & ~sticky_clr) | (out_vld & res). Set wins over a simultaneous clear.
//  - out_rise_cnt next = sticky_clr ? rise : sat(cnt + rise). Holds at 2^CNT_W-1.
//    A rise coincident with sticky_clr counts as 1.
//  - Mode change between consecutive samples needs no flush; each sample is reduced with its own mode.
// STRUCTURE
//  - Package or_reduce_pkg: function clog4(int), typedef enum logic {RED_OR, RED_AND} red_mode_e,
//    function red_identity(red_mode_e).
//  - Sub-module or_reduce_stage #(IN_W): one registered tree level (vld, mode, IN_W bits -> ceil(IN_W/4) bits),
//    generated L times.
//  - Top holds pre-mask, edge/sticky/counter logic.
// TESTING (N_IN=16, L=2 unless noted)
//  1. rst_n=0 for 3 cycles with in_vld=1, data=FFFF -> every output 0. After release, no out_vld until 2 cycles after the next in_vld.
//  2. OR mode, mask FFFF, data 0000 then 0100 on consecutive cycles -> out_vld at t+2,t+3.
//     out_res 0 then 1. out_rise at t+3, cnt=1, sticky=1.
//  3. OR mode, data 00F0, mask FF0F -> 0. AND mode, data FF0F, mask FF0F -> 1. AND mode, mask 0000 -> 1.
//  4. sticky_clr in the same cycle as a valid 1 result -> sticky stays 1. sticky_clr alone -> sticky 0 and cnt 0 next cycle.
//  5. CNT_W=2, 5 rise events -> out_rise_cnt saturates at 3.
//  6. in_vld 1,0,1 with results 1,x,0 -> out_vld 1,0,1 delayed 2 cycles. out_res holds 1 in the bubble, then out_fall pulses.
//     Repeat with N_IN=1 (L=1) and N_IN=17 (L=3).

Source files
------------

// File: rtl/or_reduce_pkg.sv
// Shared types and elaboration-time helpers for the pipelined OR/AND reduction tree.
// The widths of the tree levels are computed here, so every file sizes the levels the same way.
package or_reduce_pkg;

   typedef enum logic {RED_OR = 1'b0, RED_AND = 1'b1} red_mode_e;

   // Number of radix-4 levels needed to cover n lanes (0 for n <= 1).
   function automatic int clog4(input int n);
      int     lvl;
      longint cap;
      lvl = 32'sd0;
      cap = 64'sd1;
      for (int i = 0; i < 32; i++) begin
         if (cap < longint'(n)) begin
            cap = cap * 64'sd4;
            lvl = lvl + 32'sd1;
         end
      end
      return lvl;
   endfunction

   // Width of the data word entering tree level k.
   function automatic int lvl_width(input int n, input int k);
      int w;
      w = n;
      for (int i = 0; i < 32; i++) begin
         if (i < k) begin
            w = (w + 32'sd3) / 32'sd4;
         end
      end
      return w;
   endfunction

   function automatic logic red_identity(input red_mode_e mode);
      logic id;
      case (mode)
         RED_AND: id = 1'b1;
         RED_OR:  id = 1'b0;
         default: id = 1'b0;
      endcase
      return id;
   endfunction

   function automatic logic reduce4(input logic [3:0] grp, input red_mode_e mode);
      logic r;
      case (mode)
         RED_AND: r = &grp;
         RED_OR:  r = |grp;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/or_reduce_stage.sv
// One registered radix-4 tree level: reduces IN_W bits to ceil(IN_W/4) bits.
// The mode travels with the data, and bubbles leave the data registers untouched.
module or_reduce_stage
   import or_reduce_pkg::*;
#(
   parameter int IN_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_vld,
   input  red_mode_e                  in_mode,
   input  logic [IN_W-1:0]            in_data,
   output logic                       out_vld,
   output red_mode_e                  out_mode,
   output logic [((IN_W+3)/4)-1:0]    out_data
);

   localparam int OUT_W = (IN_W + 3) / 4;
   localparam int PAD_W = OUT_W * 4;

   logic [PAD_W-1:0] pad_s;
   logic [OUT_W-1:0] red_s;

   // The lanes of a partial top group are padded with the identity of the sample's mode.
   always_comb begin
      pad_s = {PAD_W{red_identity(in_mode)}};
      pad_s[IN_W-1:0] = in_data;
      red_s = '0;
      for (int g = 0; g < OUT_W; g++) begin
         red_s[g] = reduce4(pad_s[4*g +: 4], in_mode);
      end
   end

   // Level register; the data and mode registers load only on valid samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_mode <= RED_OR;
         out_data <= '0;
      end else begin
         out_vld <= in_vld;
         if (in_vld) begin
            out_mode <= in_mode;
            out_data <= red_s;
         end
      end
   end

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined, masked N_IN-lane OR/AND reduction with edge pulses, a sticky flag and a saturating rise counter.
// The last tree level lives here so that edge detection sees the reduced bit in the same cycle it is registered.
module or_reduce_pipe
   import or_reduce_pkg::*;
#(
   parameter int N_IN  = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   input  logic [N_IN-1:0]  in_data,
   input  logic [N_IN-1:0]  in_mask,
   input  logic             in_mode_and,
   input  logic             sticky_clr,
   output logic             out_vld,
   output logic             out_res,
   output logic             out_rise,
   output logic             out_fall,
   output logic             out_sticky,
   output logic [CNT_W-1:0] out_rise_cnt
);

   localparam int L_RAW = clog4(N_IN);
   localparam int L     = (L_RAW < 1) ? 1 : L_RAW;
   localparam int FIN_W = lvl_width(N_IN, L - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   red_mode_e        mode_s;
   logic [N_IN-1:0]  pre_s;

   // Masked-out lanes are forced to the identity of the selected reduction.
   always_comb begin
      if (in_mode_and) begin
         mode_s = RED_AND;
         pre_s  = in_data | ~in_mask;
      end else begin
         mode_s = RED_OR;
         pre_s  = in_data & in_mask;
      end
   end

   for (genvar k = 0; k < L - 1; k++) begin : g_lvl
      localparam int IW = lvl_width(N_IN, k);
      localparam int OW = lvl_width(N_IN, k + 1);
      logic          v_in;
      red_mode_e     m_in;
      logic [IW-1:0] d_in;
      logic          v_out;
      red_mode_e     m_out;
      logic [OW-1:0] d_out;
      if (k == 0) begin : g_head
         assign v_in = in_vld;
         assign m_in = mode_s;
         assign d_in = pre_s;
      end else begin : g_link
         assign v_in = g_lvl[k-1].v_out;
         assign m_in = g_lvl[k-1].m_out;
         assign d_in = g_lvl[k-1].d_out;
      end
      or_reduce_stage #(.IN_W(IW)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_vld   (v_in),
         .in_mode  (m_in),
         .in_data  (d_in),
         .out_vld  (v_out),
         .out_mode (m_out),
         .out_data (d_out)
      );
   end

   logic             fin_vld_s;
   red_mode_e        fin_mode_s;
   logic [FIN_W-1:0] fin_data_s;

   if (L == 1) begin : g_direct
      assign fin_vld_s  = in_vld;
      assign fin_mode_s = mode_s;
      assign fin_data_s = pre_s;
   end else begin : g_tail
      assign fin_vld_s  = g_lvl[L-2].v_out;
      assign fin_mode_s = g_lvl[L-2].m_out;
      assign fin_data_s = g_lvl[L-2].d_out;
   end

   logic [3:0] fin_pad_s;
   logic       res_s;

   // Final level: at most four lanes left, padded to a full group.
   always_comb begin
      fin_pad_s = {4{red_identity(fin_mode_s)}};
      fin_pad_s[FIN_W-1:0] = fin_data_s;
      res_s = reduce4(fin_pad_s, fin_mode_s);
   end

   // Result register; out_res doubles as the previous valid result for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_res  <= 1'b0;
         out_rise <= 1'b0;
         out_fall <= 1'b0;
      end else begin
         out_vld  <= fin_vld_s;
         out_rise <= fin_vld_s & res_s & ~out_res;
         out_fall <= fin_vld_s & ~res_s & out_res;
         if (fin_vld_s) begin
            out_res <= res_s;
         end
      end
   end

   // Status: a set beats a simultaneous clear, and a rise coincident with a clear counts as one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_sticky   <= 1'b0;
         out_rise_cnt <= '0;
      end else begin
         out_sticky <= (out_sticky & ~sticky_clr) | (out_vld & out_res);
         if (sticky_clr) begin
            out_rise_cnt <= CNT_W'(out_rise);
         end else if (out_rise && (out_rise_cnt != CNT_MAX)) begin
            out_rise_cnt <= out_rise_cnt + CNT_W'(1'b1);
         end else begin
            out_rise_cnt <= out_rise_cnt;
         end
      end
   end

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Bench for or_reduce_pipe: three instances (16 lanes/8-bit count, 17 lanes/2-bit count, 1 lane/3-bit count)
// share one stimulus stream and are compared every cycle with a queue-style reference model.
module tb_or_reduce_pipe;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_vld;
   logic        in_mode_and;
   logic        sticky_clr;
   logic [16:0] in_data;
   logic [16:0] in_mask;

   logic       a_vld, a_res, a_rise, a_fall, a_sticky;
   logic [7:0] a_cnt;
   logic       b_vld, b_res, b_rise, b_fall, b_sticky;
   logic [1:0] b_cnt;
   logic       c_vld, c_res, c_rise, c_fall, c_sticky;
   logic [2:0] c_cnt;

   or_reduce_pipe #(.N_IN(16), .CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data[15:0]), .in_mask(in_mask[15:0]),
      .in_mode_and(in_mode_and), .sticky_clr(sticky_clr), .out_vld(a_vld), .out_res(a_res),
      .out_rise(a_rise), .out_fall(a_fall), .out_sticky(a_sticky), .out_rise_cnt(a_cnt));

   or_reduce_pipe #(.N_IN(17), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data), .in_mask(in_mask),
      .in_mode_and(in_mode_and), .sticky_clr(sticky_clr), .out_vld(b_vld), .out_res(b_res),
      .out_rise(b_rise), .out_fall(b_fall), .out_sticky(b_sticky), .out_rise_cnt(b_cnt));

   or_reduce_pipe #(.N_IN(1), .CNT_W(3)) u_c (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data[0:0]), .in_mask(in_mask[0:0]),
      .in_mode_and(in_mode_and), .sticky_clr(sticky_clr), .out_vld(c_vld), .out_res(c_res),
      .out_rise(c_rise), .out_fall(c_fall), .out_sticky(c_sticky), .out_rise_cnt(c_cnt));

   logic       o_vld[3], o_res[3], o_rise[3], o_fall[3], o_sticky[3];
   logic [7:0] o_cnt[3];
   assign o_vld[0] = a_vld;  assign o_res[0] = a_res;  assign o_rise[0] = a_rise;
   assign o_fall[0] = a_fall; assign o_sticky[0] = a_sticky; assign o_cnt[0] = a_cnt;
   assign o_vld[1] = b_vld;  assign o_res[1] = b_res;  assign o_rise[1] = b_rise;
   assign o_fall[1] = b_fall; assign o_sticky[1] = b_sticky; assign o_cnt[1] = {6'd0, b_cnt};
   assign o_vld[2] = c_vld;  assign o_res[2] = c_res;  assign o_rise[2] = c_rise;
   assign o_fall[2] = c_fall; assign o_sticky[2] = c_sticky; assign o_cnt[2] = {5'd0, c_cnt};

   // Per-instance geometry: lane count, pipeline latency, counter ceiling.
   int nn[3]   = '{16, 17, 1};
   int ll[3]   = '{2, 3, 1};
   int cmax[3] = '{255, 3, 7};

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state: expected outputs and a per-instance delay line of {valid, result}.
   bit m_vld[3], m_res[3], m_rise[3], m_fall[3], m_sticky[3];
   int m_cnt[3];
   bit pv[3][4];
   bit pr[3][4];

   // OR: any unmasked lane is 1.  AND: no unmasked lane is 0.  Masked-out lanes never count.
   function automatic bit ref_red(input logic [16:0] d, input logic [16:0] m, input logic am, input int n);
      int hits;
      hits = 0;
      for (int i = 0; i < n; i++) begin
         if (am ? (m[i] && !d[i]) : (m[i] && d[i])) hits++;
      end
      return am ? (hits == 0) : (hits != 0);
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            m_vld[d] = 1'b0; m_res[d] = 1'b0; m_rise[d] = 1'b0; m_fall[d] = 1'b0;
            m_sticky[d] = 1'b0; m_cnt[d] = 0;
            for (int s = 0; s < 4; s++) begin pv[d][s] = 1'b0; pr[d][s] = 1'b0; end
         end else begin
            bit nst, ev, er;
            int ncnt;
            nst  = (m_sticky[d] && !sticky_clr) || (m_vld[d] && m_res[d]);
            ncnt = sticky_clr ? int'(m_rise[d]) : m_cnt[d] + int'(m_rise[d]);
            if (ncnt > cmax[d]) ncnt = cmax[d];
            for (int s = 3; s > 0; s--) begin pv[d][s] = pv[d][s-1]; pr[d][s] = pr[d][s-1]; end
            pv[d][0] = in_vld;
            pr[d][0] = ref_red(in_data, in_mask, in_mode_and, nn[d]);
            ev = pv[d][ll[d]-1];
            er = pr[d][ll[d]-1];
            m_rise[d] = ev && er && !m_res[d];
            m_fall[d] = ev && !er && m_res[d];
            if (ev) m_res[d] = er;
            m_vld[d]    = ev;
            m_sticky[d] = nst;
            m_cnt[d]    = ncnt;
         end
      end
   end

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, d, $time, got, exp);
      end
   endtask

   task automatic check_model();
      for (int d = 0; d < 3; d++) begin
         chk("vld", d, 32'(o_vld[d]), 32'(m_vld[d]));
         chk("res", d, 32'(o_res[d]), 32'(m_res[d]));
         chk("rise", d, 32'(o_rise[d]), 32'(m_rise[d]));
         chk("fall", d, 32'(o_fall[d]), 32'(m_fall[d]));
         chk("sticky", d, 32'(o_sticky[d]), 32'(m_sticky[d]));
         chk("cnt", d, 32'(o_cnt[d]), 32'(m_cnt[d]));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_model();
   endtask

   task automatic drive(input logic v, input logic [16:0] d, input logic [16:0] m, input logic am);
      in_vld = v; in_data = d; in_mask = m; in_mode_and = am;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 17'h0, 17'h1FFFF, 1'b0);
      sticky_clr = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [16:0] data;
      logic [16:0] mask;
      logic        mode_and;
      logic        exp16;
   } vec_t;
   vec_t tbl[8];

   initial begin
      tbl[0] = '{17'h00000, 17'h0FFFF, 1'b0, 1'b0};
      tbl[1] = '{17'h00100, 17'h0FFFF, 1'b0, 1'b1};
      tbl[2] = '{17'h000F0, 17'h0FF0F, 1'b0, 1'b0};
      tbl[3] = '{17'h0FF0F, 17'h0FF0F, 1'b1, 1'b1};
      tbl[4] = '{17'h00000, 17'h00000, 1'b1, 1'b1};
      tbl[5] = '{17'h0FFFE, 17'h0FFFF, 1'b1, 1'b0};
      tbl[6] = '{17'h08000, 17'h08000, 1'b0, 1'b1};
      tbl[7] = '{17'h00001, 17'h00001, 1'b1, 1'b1};

      // Reset held for 3 cycles against an active all-ones stream.
      rst_n = 1'b0;
      sticky_clr = 1'b0;
      drive(1'b1, 17'h1FFFF, 17'h1FFFF, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      chk("rst_vld", 0, 32'(a_vld), 32'd0);
      chk("rst_res", 0, 32'(a_res), 32'd0);
      chk("rst_rise", 0, 32'(a_rise), 32'd0);
      chk("rst_sticky", 0, 32'(a_sticky), 32'd0);
      chk("rst_cnt", 0, 32'(a_cnt), 32'd0);
      rst_n = 1'b1;
      drive(1'b0, 17'h1FFFF, 17'h1FFFF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_vld", 0, 32'(a_vld), 32'd0);
      end
      drive(1'b1, 17'h0, 17'h1FFFF, 1'b0);
      tick();
      chk("lat_vld0", 0, 32'(a_vld), 32'd0);
      drive(1'b0, 17'h0, 17'h1FFFF, 1'b0);
      tick();
      chk("lat_vld1", 0, 32'(a_vld), 32'd1);

      // Table: back-to-back samples with mode changes, checked two cycles later.
      for (int i = 0; i < 10; i++) begin
         if (i < 8) drive(1'b1, tbl[i].data, tbl[i].mask, tbl[i].mode_and);
         else drive(1'b0, 17'h0, 17'h0, 1'b0);
         tick();
         if (i >= 1 && i <= 8) begin
            chk("tbl_vld", 0, 32'(a_vld), 32'd1);
            chk("tbl_res", 0, 32'(a_res), 32'(tbl[i-1].exp16));
         end
      end

      // 0000 then 0100: out_res 0 then 1, a rise, then sticky and count follow.
      do_reset();
      drive(1'b1, 17'h00000, 17'h1FFFF, 1'b0);
      tick();
      drive(1'b1, 17'h00100, 17'h1FFFF, 1'b0);
      tick();
      chk("s2_vld_a", 0, 32'(a_vld), 32'd1);
      chk("s2_res_a", 0, 32'(a_res), 32'd0);
      drive(1'b0, 17'h0, 17'h1FFFF, 1'b0);
      tick();
      chk("s2_res_b", 0, 32'(a_res), 32'd1);
      chk("s2_rise_b", 0, 32'(a_rise), 32'd1);
      tick();
      chk("s2_cnt", 0, 32'(a_cnt), 32'd1);
      chk("s2_sticky", 0, 32'(a_sticky), 32'd1);

      // Clear coincident with a valid 1, then clear alone, then clear coincident with a rise.
      drive(1'b1, 17'h00100, 17'h1FFFF, 1'b0);
      tick();
      drive(1'b0, 17'h0, 17'h1FFFF, 1'b0);
      tick();
      sticky_clr = 1'b1;
      tick();
      chk("s4_sticky_set", 0, 32'(a_sticky), 32'd1);
      chk("s4_cnt_clr", 0, 32'(a_cnt), 32'd0);
      tick();
      chk("s4_sticky_clr", 0, 32'(a_sticky), 32'd0);
      sticky_clr = 1'b0;
      drive(1'b1, 17'h00000, 17'h1FFFF, 1'b0);
      tick();
      drive(1'b1, 17'h00100, 17'h1FFFF, 1'b0);
      tick();
      drive(1'b0, 17'h0, 17'h1FFFF, 1'b0);
      tick();
      chk("s4_rise", 0, 32'(a_rise), 32'd1);
      sticky_clr = 1'b1;
      tick();
      chk("s4_cnt_rise_clr", 0, 32'(a_cnt), 32'd1);
      sticky_clr = 1'b0;

      // Five rise events: 2-bit counter saturates at 3, wider counters reach 5.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, (i % 2 == 0) ? 17'h1FFFF : 17'h00000, 17'h1FFFF, 1'b0);
         tick();
      end
      drive(1'b0, 17'h0, 17'h1FFFF, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_cnt2", 1, 32'(b_cnt), 32'd3);
      chk("sat_cnt8", 0, 32'(a_cnt), 32'd5);
      chk("sat_cnt3", 2, 32'(c_cnt), 32'd5);

      // Valid pattern 1,0,1 with results 1,x,0 on all three latencies.
      do_reset();
      for (int j = 0; j < 6; j++) begin
         case (j)
            0:       drive(1'b1, 17'h1FFFF, 17'h1FFFF, 1'b0);
            1:       drive(1'b0, 17'h00000, 17'h1FFFF, 1'b0);
            2:       drive(1'b1, 17'h00000, 17'h1FFFF, 1'b0);
            default: drive(1'b0, 17'h1FFFF, 17'h1FFFF, 1'b0);
         endcase
         tick();
         for (int d = 0; d < 3; d++) begin
            chk("bub_vld", d, 32'(o_vld[d]), 32'((j == ll[d]-1) || (j == ll[d]+1)));
            chk("bub_res", d, 32'(o_res[d]), 32'((j >= ll[d]-1) && (j < ll[d]+1)));
            chk("bub_rise", d, 32'(o_rise[d]), 32'(j == ll[d]-1));
            chk("bub_fall", d, 32'(o_fall[d]), 32'(j == ll[d]+1));
         end
      end

      // Random traffic with occasional resets and clears against the reference model.
      for (int i = 0; i < 600; i++) begin
         logic [16:0] m;
         rst_n = ($urandom_range(0, 59) != 0);
         sticky_clr = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       m = 17'h1FFFF;
            1:       m = 17'h00000;
            2:       m = 17'($urandom);
            default: m = 17'($urandom & $urandom);
         endcase
         if ($urandom_range(0, 1) == 0)
            drive($urandom_range(0, 3) != 0, 17'($urandom & $urandom & $urandom), m, 1'b0);
         else
            drive($urandom_range(0, 3) != 0, 17'($urandom | $urandom | $urandom), m, 1'b1);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
